// File: rtl/ex_stage_mc.sv
// Execute stage: ID/EX register with valid/ready handshake, ALU, branch target,
// write-back address select and an iterative shift-add multiplier feeding HI/LO.
module ex_stage_mc #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int MUL_BPC = 1
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   input  logic [DATA_W-1:0]  PCPlus4_in,
   input  logic [DATA_W-1:0]  imm_signExtended_in,
   input  logic [DATA_W-1:0]  imm_zeroExtended_in,
   input  logic [DATA_W-1:0]  rs_reg_in,
   input  logic [DATA_W-1:0]  rt_reg_in,
   input  logic [RADDR_W-1:0] rt_addr_in,
   input  logic [RADDR_W-1:0] rd_addr_in,
   input  logic [4:0]         shamt_in,
   input  logic               RegWriteD,
   input  logic               MemtoRegD,
   input  logic               MemWriteD,
   input  logic               BranchD,
   input  logic               JumpD,
   input  logic               RegDstD,
   input  logic [5:0]         ALUopD,
   input  logic [5:0]         ALUfunctD,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               RegWriteE,
   output logic               MemtoRegE,
   output logic               MemWriteE,
   output logic               BranchE,
   output logic               JumpE,
   output logic [5:0]         ALUopE,
   output logic [DATA_W-1:0]  WriteData_out,
   output logic [DATA_W-1:0]  PCBranch_out,
   output logic [RADDR_W-1:0] wb_addr_out,
   output logic [DATA_W-1:0]  ALUOut,
   output logic [DATA_W-1:0]  hi_out,
   output logic [DATA_W-1:0]  lo_out,
   output logic               busy
);

   localparam int L     = DATA_W / MUL_BPC;
   localparam int CNT_W = $clog2(L + 1);

   typedef enum logic {IDLE, MUL} state_t;

   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
      return (sgn && x[DATA_W-1]) ? (~x + 1'b1) : x;
   endfunction

   function automatic logic [2*DATA_W-1:0] cond_neg(input logic [2*DATA_W-1:0] p, input logic n);
      return n ? (~p + 1'b1) : p;
   endfunction

   function automatic logic [2*DATA_W-1:0] mul_step(input logic [2*DATA_W-1:0] acc,
                                                    input logic [2*DATA_W-1:0] mc,
                                                    input logic [MUL_BPC-1:0]  bits);
      logic [2*DATA_W-1:0] r;
      r = acc;
      for (int i = 0; i < MUL_BPC; i++)
         if (bits[i]) r = r + (mc << i);
      return r;
   endfunction

   logic               vld_p1;
   logic [DATA_W-1:0]  pc4_p1, imms_p1, immz_p1, rs_p1, rt_p1;
   logic [RADDR_W-1:0] rta_p1, rda_p1;
   logic [4:0]         shamt_p1;
   logic               regw_p1, m2r_p1, memw_p1, br_p1, jmp_p1, rdst_p1;
   logic [5:0]         op_p1, fn_p1;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [2*DATA_W-1:0] mcand, acc, acc_nxt;
   logic [DATA_W-1:0]   mplier;
   logic                neg;
   logic [DATA_W-1:0]   hi, lo;

   logic cap, is_mul, mul_sgn;
   logic signed [DATA_W-1:0] rs_s, rt_s, sra_s;
   logic [DATA_W-1:0] alu;

   assign busy      = (state == MUL);
   assign in_ready  = !busy && (!vld_p1 || out_ready);
   assign out_valid = vld_p1 && !busy;
   assign cap       = in_valid && in_ready && !flush;
   assign is_mul    = (ALUopD == 6'h00) && ((ALUfunctD == 6'h18) || (ALUfunctD == 6'h19));
   assign mul_sgn   = (ALUfunctD == 6'h18);

   // ---- stage p1: ID/EX register ----
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         vld_p1   <= 1'b0;
         pc4_p1   <= '0;
         imms_p1  <= '0;
         immz_p1  <= '0;
         rs_p1    <= '0;
         rt_p1    <= '0;
         rta_p1   <= '0;
         rda_p1   <= '0;
         shamt_p1 <= '0;
         regw_p1  <= 1'b0;
         m2r_p1   <= 1'b0;
         memw_p1  <= 1'b0;
         br_p1    <= 1'b0;
         jmp_p1   <= 1'b0;
         rdst_p1  <= 1'b0;
         op_p1    <= '0;
         fn_p1    <= '0;
      end else begin
         if (flush)                         vld_p1 <= 1'b0;
         else if (cap)                      vld_p1 <= 1'b1;
         else if (out_valid && out_ready)   vld_p1 <= 1'b0;
         if (cap) begin
            pc4_p1   <= PCPlus4_in;
            imms_p1  <= imm_signExtended_in;
            immz_p1  <= imm_zeroExtended_in;
            rs_p1    <= rs_reg_in;
            rt_p1    <= rt_reg_in;
            rta_p1   <= rt_addr_in;
            rda_p1   <= rd_addr_in;
            shamt_p1 <= shamt_in;
            regw_p1  <= RegWriteD;
            m2r_p1   <= MemtoRegD;
            memw_p1  <= MemWriteD;
            br_p1    <= BranchD;
            jmp_p1   <= JumpD;
            rdst_p1  <= RegDstD;
            op_p1    <= ALUopD;
            fn_p1    <= ALUfunctD;
         end
      end
   end

   // ---- multiplier: magnitudes loaded at capture, sign fixed up on the final cycle ----
   assign acc_nxt = mul_step(acc, mcand, mplier[MUL_BPC-1:0]);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state  <= IDLE;
         cnt    <= '0;
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (cap && is_mul) begin
               state  <= MUL;
               cnt    <= '0;
               acc    <= '0;
               mcand  <= {{DATA_W{1'b0}}, mag(rs_reg_in, mul_sgn)};
               mplier <= mag(rt_reg_in, mul_sgn);
               neg    <= mul_sgn && (rs_reg_in[DATA_W-1] ^ rt_reg_in[DATA_W-1]);
            end
            MUL: begin
               acc    <= acc_nxt;
               mcand  <= mcand << MUL_BPC;
               mplier <= mplier >> MUL_BPC;
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_W'(L - 1)) begin
                  {hi, lo} <= cond_neg(acc_nxt, neg);
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---- stage p1 combinational: ALU, branch target, write-back select ----
   assign rs_s  = rs_p1;
   assign rt_s  = rt_p1;
   assign sra_s = rt_s >>> shamt_p1;

   always_comb begin
      alu = '0;
      case (op_p1)
         6'h00: case (fn_p1)
            6'h20, 6'h21: alu = rs_p1 + rt_p1;
            6'h22, 6'h23: alu = rs_p1 - rt_p1;
            6'h24:        alu = rs_p1 & rt_p1;
            6'h25:        alu = rs_p1 | rt_p1;
            6'h26:        alu = rs_p1 ^ rt_p1;
            6'h27:        alu = ~(rs_p1 | rt_p1);
            6'h2A:        alu = {{(DATA_W-1){1'b0}}, (rs_s < rt_s)};
            6'h2B:        alu = {{(DATA_W-1){1'b0}}, (rs_p1 < rt_p1)};
            6'h00:        alu = rt_p1 << shamt_p1;
            6'h02:        alu = rt_p1 >> shamt_p1;
            6'h03:        alu = sra_s;
            6'h10:        alu = hi;
            6'h12:        alu = lo;
            default:      alu = '0;
         endcase
         6'h08, 6'h09, 6'h23, 6'h2B: alu = rs_p1 + imms_p1;
         6'h0C:                      alu = rs_p1 & immz_p1;
         6'h0D:                      alu = rs_p1 | immz_p1;
         6'h04, 6'h05:               alu = rs_p1 - rt_p1;
         6'h03:                      alu = pc4_p1;
         default:                    alu = '0;
      endcase
   end

   assign ALUOut        = alu;
   assign PCBranch_out  = pc4_p1 + (imms_p1 << 2);
   assign wb_addr_out   = (op_p1 == 6'h03) ? RADDR_W'(31) : (rdst_p1 ? rda_p1 : rta_p1);
   assign WriteData_out = rt_p1;
   assign ALUopE        = op_p1;
   assign RegWriteE     = regw_p1 && out_valid;
   assign MemtoRegE     = m2r_p1  && out_valid;
   assign MemWriteE     = memw_p1 && out_valid;
   assign BranchE       = br_p1   && out_valid;
   assign JumpE         = jmp_p1  && out_valid;
   assign hi_out        = hi;
   assign lo_out        = lo;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: handshake, ALU ops, branch/jal, multiply latency,
// flush abort, MEM stall and asynchronous reset during a multiply.
module tb_ex_stage_mc;

   logic        CLK, RESET, in_valid, in_ready, flush;
   logic [31:0] PCPlus4_in, imm_signExtended_in, imm_zeroExtended_in, rs_reg_in, rt_reg_in;
   logic [4:0]  rt_addr_in, rd_addr_in, shamt_in;
   logic        RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, RegDstD;
   logic [5:0]  ALUopD, ALUfunctD;
   logic        out_valid, out_ready;
   logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE;
   logic [5:0]  ALUopE;
   logic [31:0] WriteData_out, PCBranch_out, ALUOut, hi_out, lo_out;
   logic [4:0]  wb_addr_out;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int n;

   ex_stage_mc #(.DATA_W(32), .RADDR_W(5), .MUL_BPC(1)) dut (
      .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .PCPlus4_in(PCPlus4_in), .imm_signExtended_in(imm_signExtended_in),
      .imm_zeroExtended_in(imm_zeroExtended_in), .rs_reg_in(rs_reg_in), .rt_reg_in(rt_reg_in),
      .rt_addr_in(rt_addr_in), .rd_addr_in(rd_addr_in), .shamt_in(shamt_in),
      .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .BranchD(BranchD),
      .JumpD(JumpD), .RegDstD(RegDstD), .ALUopD(ALUopD), .ALUfunctD(ALUfunctD),
      .out_valid(out_valid), .out_ready(out_ready),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .BranchE(BranchE),
      .JumpE(JumpE), .ALUopE(ALUopE), .WriteData_out(WriteData_out), .PCBranch_out(PCBranch_out),
      .wb_addr_out(wb_addr_out), .ALUOut(ALUOut), .hi_out(hi_out), .lo_out(lo_out), .busy(busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clr();
      PCPlus4_in = '0; imm_signExtended_in = '0; imm_zeroExtended_in = '0;
      rs_reg_in = '0; rt_reg_in = '0; rt_addr_in = '0; rd_addr_in = '0; shamt_in = '0;
      RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; BranchD = 0; JumpD = 0; RegDstD = 0;
      ALUopD = '0; ALUfunctD = '0;
   endtask

   task automatic issue();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic rtype(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
      clr();
      ALUfunctD = fn; rs_reg_in = a; rt_reg_in = b; shamt_in = sh;
      issue();
      chk(tag, ALUOut, exp);
   endtask

   initial begin
      clr();
      in_valid = 0; flush = 0; out_ready = 1; RESET = 1;
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_hi", hi_out, 0);
      chk("rst_lo", lo_out, 0);
      chk("rst_aluout", ALUOut, 0);
      chk("rst_regwrite", RegWriteE, 0);
      chk("rst_pcbranch", PCBranch_out, 0);
      repeat (2) step();
      RESET = 0;

      // add with signed wrap
      clr();
      rs_reg_in = 32'h7FFFFFFF; rt_reg_in = 32'h1; RegDstD = 1; rd_addr_in = 3; rt_addr_in = 2;
      RegWriteD = 1; ALUfunctD = 6'h20;
      issue();
      chk("add_valid", out_valid, 1);
      chk("add_alu", ALUOut, 32'h80000000);
      chk("add_wb", wb_addr_out, 3);
      chk("add_regwrite", RegWriteE, 1);
      chk("add_memwrite", MemWriteE, 0);

      // beq with negative offset
      clr();
      ALUopD = 6'h04; PCPlus4_in = 32'h100; imm_signExtended_in = 32'hFFFFFFFE;
      rs_reg_in = 5; rt_reg_in = 5; BranchD = 1;
      issue();
      chk("beq_target", PCBranch_out, 32'hF8);
      chk("beq_branch", BranchE, 1);
      chk("beq_alu", ALUOut, 0);
      chk("beq_regwrite", RegWriteE, 0);

      // signed mult, mflo waiting behind it
      clr();
      ALUfunctD = 6'h18; rs_reg_in = 32'hFFFFFFFD; rt_reg_in = 32'd7;
      in_valid = 1;
      step();
      clr();
      ALUfunctD = 6'h12; RegDstD = 1; rd_addr_in = 4; RegWriteD = 1;
      for (int i = 0; i < 32; i++) begin
         chk("mult_busy", busy, 1);
         chk("mult_in_ready", in_ready, 0);
         step();
      end
      chk("mult_done_busy", busy, 0);
      chk("mult_out_valid", out_valid, 1);
      chk("mult_regwrite", RegWriteE, 0);
      chk("mult_hi", hi_out, 32'hFFFFFFFF);
      chk("mult_lo", lo_out, 32'hFFFFFFEB);
      step();
      in_valid = 0;
      chk("mflo_valid", out_valid, 1);
      chk("mflo_alu", ALUOut, 32'hFFFFFFEB);
      chk("mflo_wb", wb_addr_out, 4);

      // multu full-scale
      clr();
      ALUfunctD = 6'h19; rs_reg_in = 32'hFFFFFFFF; rt_reg_in = 32'hFFFFFFFF;
      issue();
      n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
      chk("multu_latency", n, 32);
      chk("multu_hi", hi_out, 32'hFFFFFFFE);
      chk("multu_lo", lo_out, 32'h00000001);

      // second multu aborted by flush
      clr();
      ALUfunctD = 6'h19; rs_reg_in = 32'd2; rt_reg_in = 32'd3;
      issue();
      chk("multu2_busy", busy, 1);
      repeat (9) step();
      flush = 1;
      step();
      flush = 0;
      chk("flush_busy", busy, 0);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_hi", hi_out, 32'hFFFFFFFE);
      chk("flush_lo", lo_out, 32'h00000001);
      repeat (40) step();
      chk("flush_hi_later", hi_out, 32'hFFFFFFFE);
      chk("flush_lo_later", lo_out, 32'h00000001);

      // MEM stall
      clr();
      ALUopD = 6'h0D; rs_reg_in = 32'h1200; imm_zeroExtended_in = 32'h34; rt_addr_in = 9;
      RegWriteD = 1;
      out_ready = 0;
      issue();
      clr();
      ALUfunctD = 6'h26; rs_reg_in = 32'hF0F0; rt_reg_in = 32'hFF00; RegDstD = 1;
      rd_addr_in = 10; RegWriteD = 1;
      in_valid = 1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_in_ready", in_ready, 0);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_alu", ALUOut, 32'h1234);
         chk("stall_wb", wb_addr_out, 9);
         step();
      end
      out_ready = 1;
      #1;
      chk("unstall_in_ready", in_ready, 1);
      step();
      in_valid = 0;
      chk("xor_alu", ALUOut, 32'h0FF0);
      chk("xor_wb", wb_addr_out, 10);

      // flush together with a new instruction
      clr();
      ALUopD = 6'h2B; MemWriteD = 1; RegWriteD = 1;
      in_valid = 1; flush = 1;
      step();
      in_valid = 0; flush = 0;
      chk("flushcap_valid", out_valid, 0);
      chk("flushcap_regwrite", RegWriteE, 0);
      chk("flushcap_memwrite", MemWriteE, 0);

      // assorted R-type ops
      rtype("sra", 6'h03, 32'h0, 32'h80000000, 5'd4, 32'hF8000000);
      rtype("srl", 6'h02, 32'h0, 32'h80000000, 5'd4, 32'h08000000);
      rtype("slt", 6'h2A, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1);
      rtype("sltu", 6'h2B, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0);
      rtype("sub", 6'h22, 32'h0, 32'h1, 5'd0, 32'hFFFFFFFF);
      rtype("nor", 6'h27, 32'h0F0F0000, 32'h000000F0, 5'd0, 32'hF0F0FF0F);

      // jal
      clr();
      ALUopD = 6'h03; PCPlus4_in = 32'h40; JumpD = 1; RegWriteD = 1;
      issue();
      chk("jal_alu", ALUOut, 32'h40);
      chk("jal_wb", wb_addr_out, 31);
      chk("jal_jump", JumpE, 1);

      // reset while the multiplier iterates
      clr();
      ALUfunctD = 6'h18; rs_reg_in = 32'd5; rt_reg_in = 32'd6;
      issue();
      repeat (5) step();
      chk("prerst_busy", busy, 1);
      #2;
      RESET = 1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_hi", hi_out, 0);
      chk("midrst_lo", lo_out, 0);
      chk("midrst_in_ready", in_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised next-generation execute stage: ID/EX pipeline register, branch-target calculator, write-back address selector, ALU, and a multi-cycle iterative multiplier with HI/LO registers.
- Adds what the single-cycle EX stage lacks: valid/ready handshake with upstream (ID) and downstream (MEM), flush for taken branch/jump, and stall while MULT/MULTU iterates.
- Sits between ID_stage and MEM_stage.

Parameters:
- DATA_W, 32, datapath/register width.
- RADDR_W, 5, register-file address width.
- MUL_BPC, 1, multiplier bits retired per cycle; must divide DATA_W. Multiply latency L = DATA_W/MUL_BPC.

Ports:
- CLK  in  1  clock; all state on posedge.
- RESET  in  1  asynchronous, active-high reset.
- in_valid  in  1  ID presents a valid instruction.
- in_ready  out  1  EX accepts this cycle; transfer on in_valid&&in_ready.
- flush  in  1  kill the instruction being captured and the instruction held in EX.
- PCPlus4_in, imm_signExtended_in, imm_zeroExtended_in, rs_reg_in, rt_reg_in  in  DATA_W each  ID operands.
- rt_addr_in, rd_addr_in  in  RADDR_W each  register addresses.
- shamt_in  in  5  shift amount.
- RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, RegDstD  in  1 each  decode controls.
- ALUopD, ALUfunctD  in  6 each  opcode / funct.
- out_valid  out  1  EX result valid for MEM.
- out_ready  in  1  MEM accepts; transfer on out_valid&&out_ready.
- RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE  out  1 each  registered controls, gated by out_valid.
- ALUopE  out  6  registered opcode.
- WriteData_out  out  DATA_W  registered rt_reg.
- PCBranch_out  out  DATA_W  branch target.
- wb_addr_out  out  RADDR_W  write-back address.
- ALUOut  out  DATA_W  ALU result.
- hi_out, lo_out  out  DATA_W each  architectural HI/LO.
- busy  out  1  multiplier iterating.

Behaviour:
- Reset (async, immediate): ex_valid=0, FSM=IDLE, HI=LO=0, all pipeline registers 0. Every output reads 0 except in_ready=1.
- in_ready = !busy && (!ex_valid || out_ready). out_valid = ex_valid && !busy.
- Capture: on in_valid&&in_ready&&!flush, load all inputs and set ex_valid=1. Otherwise, if out_valid&&out_ready, clear ex_valid. If neither, hold all registers.
- flush has priority over capture and hold:
  - next edge ex_valid=0;
  - a multiply in progress aborts to IDLE with HI/LO unchanged.
- Bubble: while out_valid=0, RegWriteE, MemWriteE, BranchE, JumpE, MemtoRegE read 0. Data outputs are don't-care.
- PCBranch_out = PCPlus4 + (imm_signExtended<<2), modulo 2^DATA_W. Combinational from registered values.
- wb_addr_out: 31 if op=0x03 (jal); else rd_addr if RegDst=1; else rt_addr.
- ALU, op=0 (R-type), by funct:
  - 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor;
  - 0x2A slt (signed), 0x2B sltu;
  - 0x00 sll, 0x02 srl, 0x03 sra, by shamt;
  - 0x10 mfhi, 0x12 mflo.
- ALU, by op: 0x08/0x09 rs+sext; 0x0C rs&zext; 0x0D rs|zext; 0x23/0x2B rs+sext; 0x04/0x05 rs-rt; 0x03 PCPlus4. Any other value gives 0.
- No overflow traps. All arithmetic wraps at DATA_W.
- Multiplier FSM IDLE -> MUL -> IDLE:
  - Entered on the edge capturing funct 0x18 (signed) or 0x19 (unsigned).
  - MUL: busy=1, counter counts L cycles, retiring MUL_BPC multiplier bits per cycle by shift-add on magnitudes.
  - Signed mode: operands converted to magnitude; product negated if signs differ.
  - Final MUL cycle writes {HI,LO} (2*DATA_W product) and returns to IDLE. out_valid rises the following cycle.
  - Net result: mult occupies EX for L+1 cycles before handing off.
- MULT/MULTU instructions carry RegWriteD=0 from decode. EX does not modify GPR controls.
- mfhi/mflo captured right after a mult read the updated HI/LO, because capture is blocked while busy.
- MEM stall (out_ready=0): all registers hold, in_ready=0, outputs stable.

Test Plan:
- Reset mid-multiply: assert RESET with FSM in MUL -> busy=0, out_valid=0, hi_out=lo_out=0 immediately, without waiting for a clock edge.
- add $3,$1,$2 with rs=0x7FFFFFFF, rt=1, RegDst=1, rd=3 -> one cycle later out_valid=1, ALUOut=0x80000000, wb_addr_out=3, RegWriteE=1.
- beq with PCPlus4=0x100, imm_sext=0xFFFFFFFE -> PCBranch_out=0xF8, BranchE=1.
- mult rs=0xFFFFFFFD (-3), rt=7, MUL_BPC=1 -> busy for 32 cycles, in_ready=0 throughout. Then HI=0xFFFFFFFF, LO=0xFFFFFFEB. A following mflo -> ALUOut=0xFFFFFFEB.
- multu rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Flush at cycle 10 of a second multu -> HI/LO keep these values, busy=0 next cycle.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, ALUOut/wb_addr_out stable. flush together with in_valid -> next cycle out_valid=0, RegWriteE=MemWriteE=0.
- jal with PCPlus4=0x40 -> ALUOut=0x40, wb_addr_out=31.
